lcd_write_sequencer: RTL
========================

# lcd_write_sequencer

Buffers a stream of LCD characters and commands from the CPU-side bus decode and feeds them to the memory-mapped LCD controller one at a time. It polls the controller's status register until busy clears, then writes the data or command register. It tracks the cursor on a COLS×ROWS display, inserting DDRAM-address commands automatically on line wrap and on newline (0x0A). Firmware can queue text without polling the status register itself.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, 4..64.
- COLS, 16: display columns, 1..64.
- ROWS, 2: display rows, 1 or 2.
- TIMEOUT_POLLS, 65535: consecutive busy polls before err sets; 16-bit counter.

Ports (one clock; reset is asynchronous, active-low):
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  entry offered.
- in_ready  out  1  FIFO not full; entry accepted when in_valid && in_ready.
- in_rs  in  1  1 = character (data register), 0 = command.
- in_data  in  8  character or command byte.
- lcd_cs  out  1  chip select to LCD controller.
- lcd_we  out  1  write strobe.
- lcd_rd  out  1  read strobe.
- lcd_addr  out  8  0x00 data, 0x01 command, 0x02 status.
- lcd_wdata  out  8  write data.
- lcd_rdata  in  8  controller read data, valid the cycle after lcd_rd.
- fifo_count  out  7  entries held.
- idle  out  1  FIFO empty, no wrap pending, and state IDLE.
- err  out  1  sticky busy-timeout flag.
- err_clr  in  1  clears err.

## Operation
- FIFO entries are 9 bits {rs, data}. Push and pop in the same cycle are legal, and count is unchanged.
- Cursor registers: col (6 bits) and row (1 bit). Both reset to 0.
- States are IDLE, POLL_RD, POLL_CHK, WRITE, GAP.
- IDLE, priority order:
  - If wrap_pending: load cur = {0, 0x80 | (row ? 0x40 : 0x00)}, clear wrap_pending, go to POLL_RD.
  - Else if FIFO not empty: pop the head.
  - If the head is rs=1 and 0x0A: write nothing; col ← 0, row ← (row+1) mod ROWS, set wrap_pending, stay IDLE.
  - Otherwise cur ← head, go to POLL_RD.
- POLL_RD: lcd_cs=1, lcd_rd=1, lcd_addr=0x02 for one cycle, then go to POLL_CHK.
- POLL_CHK: sample lcd_rdata[0].
  - If 1: poll_cnt++. When poll_cnt reaches TIMEOUT_POLLS, set err; polling continues. Go to POLL_RD.
  - If 0: poll_cnt ← 0, go to WRITE.
- WRITE: lcd_cs=1, lcd_we=1, lcd_addr = cur.rs ? 0x00 : 0x01, lcd_wdata = cur.data, for exactly one cycle. Update the cursor:
  - rs=1: col++. If col+1 ≥ COLS: col ← 0, row ← (row+1) mod ROWS, set wrap_pending.
  - Command 0x01 or 0x02: col ← 0, row ← 0, clear wrap_pending.
  - Command with bit7=1: row ← data[6] (forced 0 if ROWS=1), col ← data[5:0].
  - Other commands: cursor unchanged.
- GAP: one cycle with all strobes low, then go to IDLE. This guarantees the controller's busy is registered high before the next poll.
- The LCD controller's own init period reads as busy, so entries wait in the FIFO until init completes.
- err_clr on the same cycle as a timeout: set wins.

## Timing
- Reset values: lcd_cs/we/rd = 0, lcd_addr = 0x00, lcd_wdata = 0x00, fifo_count = 0, in_ready = 1, idle = 1, err = 0, state IDLE, FIFO empty.
- All lcd_* outputs are decoded only from state and cur flops, so they are glitch-free.
- Latency: push in cycle t into an empty FIFO with the controller not busy gives IDLE pop at t+1, POLL_RD at t+2, POLL_CHK at t+3, lcd_we at t+4.
- Minimum spacing between successive write strobes is 4 cycles (GAP, IDLE, POLL_RD, POLL_CHK); a real LCD gives far more due to busy.
- Full FIFO: in_ready=0 and the offered entry is held, not dropped.
- Asserting rst_n low mid-transfer aborts immediately and discards FIFO contents. A strobe may be truncated; the controller is reset from the same source.

## Structure
- Shared header lcd_defs.vh holds:
  - Register offsets LCD_REG_DATA, LCD_REG_CMD, LCD_REG_STATUS.
  - Commands LCD_CMD_CLEAR (0x01), LCD_CMD_HOME (0x02), LCD_CMD_DDRAM (0x80).
  - LCD_ROW1_BASE (0x40).
  - State encodings.
- Sub-module lcd_cmd_fifo: synchronous 9-bit FIFO with count, DEPTH parameter, and async active-low reset.

## Test plan
- Reset, then push rs=1 0x41 with lcd_rdata=0 → POLL_RD at t+2, then lcd_we at t+4 with addr 0x00, wdata 0x41; idle=1 two cycles after the strobe.
- Hold lcd_rdata[0]=1 for 10 polls, then 0 → exactly 11 lcd_rd pulses and one write; err stays 0.
- COLS=16, ROWS=2: push 17 characters → after the 16th data write, a command write of 0xC0 precedes the 17th character. Push 16 more → 0x80 is inserted.
- Push command 0x01, then "A", 0x0A, "B" → writes are cmd 0x01, data 0x41, cmd 0xC0, data 0x42; 0x0A is never written.
- With lcd_rdata stuck busy, push 17 entries at DEPTH=16 → in_ready falls at count 16 and the 17th entry is held. With TIMEOUT_POLLS=8: err rises after 8 polls, and err_clr clears it.
- Assert rst_n low in POLL_CHK with 5 entries queued → all outputs return to reset values, fifo_count=0.

Source files
------------

// File: rtl/lcd_write_sequencer_pkg.sv
// Shared definitions for the LCD write sequencer: controller register
// offsets, command codes, FSM state type and the queued entry format.
package lcd_write_sequencer_pkg;

  localparam logic [7:0] LCD_REG_DATA   = 8'h00;
  localparam logic [7:0] LCD_REG_CMD    = 8'h01;
  localparam logic [7:0] LCD_REG_STATUS = 8'h02;

  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME   = 8'h02;
  localparam logic [7:0] LCD_CMD_DDRAM  = 8'h80;
  localparam logic [7:0] LCD_ROW1_BASE  = 8'h40;
  localparam logic [7:0] LCD_CHAR_NL    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_RD,
    ST_POLL_CHK,
    ST_WRITE,
    ST_GAP
  } lcd_state_e;

  // One queued item: rs=1 character, rs=0 command.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  // Set-DDRAM-address command pointing at column 0 of the given row.
  function automatic lcd_entry_t ddram_cmd(input logic row);
    lcd_entry_t e;
    e.rs   = 1'b0;
    e.data = LCD_CMD_DDRAM | (row ? LCD_ROW1_BASE : 8'h00);
    return e;
  endfunction

endpackage

// File: rtl/lcd_write_sequencer_fifo.sv
// lcd_cmd_fifo: synchronous FIFO of {rs, data} entries with occupancy count.
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data (head,
// show-ahead), full, empty, count. Push when full and pop when empty are ignored.
module lcd_cmd_fifo
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  lcd_entry_t push_data,
  input  logic       pop,
  output lcd_entry_t pop_data,
  output logic       full,
  output logic       empty,
  output logic [6:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  lcd_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == 7'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: queues characters/commands and writes them to a
// memory-mapped LCD controller, polling its busy bit before every write and
// tracking the cursor so line wraps and newlines emit DDRAM-address commands.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_rs/in_data input
// stream; lcd_cs/we/rd/addr/wdata/rdata controller bus; fifo_count, idle,
// err (sticky busy timeout) and err_clr.
module lcd_write_sequencer
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned COLS          = 16,
  parameter int unsigned ROWS          = 2,
  parameter int unsigned TIMEOUT_POLLS = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       lcd_cs,
  output logic       lcd_we,
  output logic       lcd_rd,
  output logic [7:0] lcd_addr,
  output logic [7:0] lcd_wdata,
  input  logic [7:0] lcd_rdata,
  output logic [6:0] fifo_count,
  output logic       idle,
  output logic       err,
  input  logic       err_clr
);

  localparam logic [15:0] TMO    = 16'(TIMEOUT_POLLS);
  localparam logic [6:0]  COLS_W = 7'(COLS);

  lcd_state_e  state;
  lcd_entry_t  cur;
  lcd_entry_t  head;
  logic [5:0]  col;
  logic        row;
  logic        next_row;
  logic        wrap_pending;
  logic [15:0] poll_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        unused_rdata;

  assign unused_rdata = ^lcd_rdata[7:1];

  assign in_ready = !fifo_full;
  assign fifo_pop = (state == ST_IDLE) && !wrap_pending && !fifo_empty;
  assign idle     = (state == ST_IDLE) && fifo_empty && !wrap_pending;
  assign next_row = (ROWS == 2) ? ~row : 1'b0;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data ({in_rs, in_data}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Bus strobes are registered alongside the state transition, so each one
  // is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur          <= '0;
      col          <= '0;
      row          <= 1'b0;
      wrap_pending <= 1'b0;
      poll_cnt     <= '0;
      err          <= 1'b0;
      lcd_cs       <= 1'b0;
      lcd_we       <= 1'b0;
      lcd_rd       <= 1'b0;
      lcd_addr     <= LCD_REG_DATA;
      lcd_wdata    <= '0;
    end else begin
      lcd_cs    <= 1'b0;
      lcd_we    <= 1'b0;
      lcd_rd    <= 1'b0;
      lcd_addr  <= LCD_REG_DATA;
      lcd_wdata <= '0;
      if (err_clr) err <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (wrap_pending) begin
            cur          <= ddram_cmd(row);
            wrap_pending <= 1'b0;
            state        <= ST_POLL_RD;
            lcd_cs       <= 1'b1;
            lcd_rd       <= 1'b1;
            lcd_addr     <= LCD_REG_STATUS;
          end else if (!fifo_empty) begin
            if (head.rs && head.data == LCD_CHAR_NL) begin
              // Newline is consumed here; the address command follows next cycle.
              col          <= '0;
              row          <= next_row;
              wrap_pending <= 1'b1;
            end else begin
              cur      <= head;
              state    <= ST_POLL_RD;
              lcd_cs   <= 1'b1;
              lcd_rd   <= 1'b1;
              lcd_addr <= LCD_REG_STATUS;
            end
          end
        end
        ST_POLL_RD: state <= ST_POLL_CHK;
        ST_POLL_CHK: begin
          if (lcd_rdata[0]) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (poll_cnt + 16'd1 == TMO) err <= 1'b1;
            state    <= ST_POLL_RD;
            lcd_cs   <= 1'b1;
            lcd_rd   <= 1'b1;
            lcd_addr <= LCD_REG_STATUS;
          end else begin
            poll_cnt  <= '0;
            state     <= ST_WRITE;
            lcd_cs    <= 1'b1;
            lcd_we    <= 1'b1;
            lcd_addr  <= cur.rs ? LCD_REG_DATA : LCD_REG_CMD;
            lcd_wdata <= cur.data;
          end
        end
        ST_WRITE: begin
          if (cur.rs) begin
            if ({1'b0, col} + 7'd1 >= COLS_W) begin
              col          <= '0;
              row          <= next_row;
              wrap_pending <= 1'b1;
            end else begin
              col <= col + 6'd1;
            end
          end else if (cur.data == LCD_CMD_CLEAR || cur.data == LCD_CMD_HOME) begin
            col          <= '0;
            row          <= 1'b0;
            wrap_pending <= 1'b0;
          end else if (cur.data[7]) begin
            row <= (ROWS == 2) ? cur.data[6] : 1'b0;
            col <= cur.data[5:0];
          end
          state <= ST_GAP;
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
